// File: rtl/ternary_stream_loader.sv
// Input sequencer for the ternary matrix-vector multiplier: assembles packed
// 2-bit weights from a byte stream, then pairs activation bytes into VecIn words.
module ternary_stream_loader #(
  parameter int InLen    = 14,
  parameter int OutLen   = 7,
  parameter int BitWidth = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          load,
  input  logic [BitWidth-1:0]           data_in,
  input  logic                          data_valid,
  output logic [2*InLen*OutLen-1:0]     W,
  output logic [2*BitWidth-1:0]         VecIn,
  output logic [2:0]                    row,
  output logic                          vec_valid,
  output logic                          vec_last,
  output logic                          w_ready
);

  localparam int WW    = 2 * InLen * OutLen;
  localparam int NB    = (WW + BitWidth - 1) / BitWidth;
  localparam int BCW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int PAIRS = InLen / 2;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);
  localparam logic [2:0]     LAST_PAIR = 3'(PAIRS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Handshake: a byte is consumed on a rising edge when en && data_valid;
  // there is no backpressure, and load (with en) takes priority over any byte.
  state_t                state, state_next;
  logic [BCW-1:0]        byte_cnt;
  logic [2:0]            pair_cnt;
  logic                  half_full;
  logic [BitWidth-1:0]   low_byte;
  logic                  accept;

  assign accept = en && data_valid;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en && load) state_next = LOAD;
      LOAD: begin
        if (en && load)                           state_next = LOAD;
        else if (accept && byte_cnt == LAST_BYTE) state_next = RUN;
      end
      RUN:  if (en && load) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      W         <= '0;
      VecIn     <= '0;
      row       <= '0;
      vec_valid <= 1'b0;
      vec_last  <= 1'b0;
      w_ready   <= 1'b0;
      byte_cnt  <= '0;
      pair_cnt  <= '0;
      half_full <= 1'b0;
      low_byte  <= '0;
    end else begin
      state     <= state_next;
      vec_valid <= 1'b0;
      vec_last  <= 1'b0;
      if (en) begin
        if (load) begin
          byte_cnt  <= '0;
          pair_cnt  <= '0;
          half_full <= 1'b0;
          w_ready   <= 1'b0;
        end else if (data_valid) begin
          case (state)
            LOAD: begin
              // The final byte only covers the remaining weight bits; its upper bits are dropped.
              for (int k = 0; k < NB; k++) begin
                if (byte_cnt == BCW'(k)) begin
                  for (int b = 0; b < BitWidth; b++) begin
                    if (k * BitWidth + b < WW) W[k * BitWidth + b] <= data_in[b];
                  end
                end
              end
              if (byte_cnt == LAST_BYTE) begin
                byte_cnt  <= '0;
                w_ready   <= 1'b1;
                pair_cnt  <= '0;
                half_full <= 1'b0;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
            RUN: begin
              if (!half_full) begin
                low_byte  <= data_in;
                half_full <= 1'b1;
              end else begin
                VecIn     <= {data_in, low_byte};
                row       <= pair_cnt;
                vec_valid <= 1'b1;
                vec_last  <= (pair_cnt == LAST_PAIR);
                pair_cnt  <= (pair_cnt == LAST_PAIR) ? 3'd0 : pair_cnt + 3'd1;
                half_full <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
